dir_seq_arbiter: RTL
====================

DIR_SEQ_ARBITER -- requirements
Module: dir_seq_arbiter

Interface
REQ-001 SHALL have parameter T_RX, default 1000, meaning cycles from accepted frame request to dir_RX assertion.
REQ-002 SHALL have parameter T_TX, default 500, meaning cycles from dir_RX assertion to dir_TX assertion.
REQ-003 SHALL have parameter T_ADDR, default 500, meaning the addr_ena window length in cycles.
REQ-004 SHALL have parameter T_REL, default 500, meaning cycles between dir_TX release and dir_RX release.
REQ-005 SHALL have parameter T_WD, default 4000, meaning the watchdog limit in cycles for the wait-for-transmit phase; all parameters lie in 1..4095.
REQ-006 SHALL have port clk, input, 1 bit: the system clock, with all logic on its rising edge.
REQ-007 SHALL have port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port frame_req, input, 1 bit: a one-cycle pulse marking a complete request frame from the MFK.
REQ-009 SHALL have port clr_req, input, 1 bit: a one-cycle pulse requesting line release.
REQ-010 SHALL have port tx_done, input, 1 bit: a one-cycle pulse marking the end of the response transmission.
REQ-011 SHALL have port dir_RX, output, 1 bit: the receiver direction control.
REQ-012 SHALL have port dir_TX, output, 1 bit: the transmitter direction control.
REQ-013 SHALL have port addr_ena, output, 1 bit: the address/data output enable window.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-015 SHALL have port state, output, 3 bits: the current FSM state code.
REQ-016 SHALL have port drop_cnt, output, 8 bits: a saturating count of discarded frame requests.
REQ-017 SHALL have port wd_err, output, 1 bit: a one-cycle pulse on watchdog expiry.

Function
REQ-018 SHALL implement states IDLE=0, RX_SW=1, TX_SW=2, ADDR=3, WAIT_TX=4, REL_TX=5, REL_RX=6; code 7 is illegal and goes to IDLE on the next cycle.
REQ-019 SHALL use a single 12-bit phase counter, cleared on every state change and incremented otherwise.
REQ-020 SHALL, in IDLE, go to RX_SW on the next edge when frame_req=1 or pending=1, and clear pending.
REQ-021 SHALL, in RX_SW when cnt==T_RX-1, set dir_RX<=1 and go to TX_SW.
REQ-022 SHALL, in TX_SW when cnt==T_TX-1, set dir_TX<=1 and addr_ena<=1, and go to ADDR.
REQ-023 SHALL, in ADDR when cnt==T_ADDR-1, set addr_ena<=0 and go to WAIT_TX, so that addr_ena is high for exactly T_ADDR cycles.
REQ-024 SHALL, in WAIT_TX, go to REL_TX on tx_done, on clr_req, or when cnt==T_WD-1; the watchdog case also pulses wd_err for one cycle.
REQ-025 SHALL, on the transition into REL_TX, set dir_TX<=0 and addr_ena<=0.
REQ-026 SHALL, in REL_TX when cnt==T_REL-1, set dir_RX<=0 and go to REL_RX.
REQ-027 SHALL hold REL_RX for exactly 1 cycle, then go to IDLE.
REQ-028 SHALL treat clr_req in RX_SW, TX_SW or ADDR as an abort: go to REL_TX on the next edge; outputs follow REQ-025/026, and a dir_RX that was never set simply stays 0.
REQ-029 SHALL ignore clr_req in IDLE, REL_TX and REL_RX.
REQ-030 SHALL, when frame_req arrives outside IDLE with pending=0, set pending<=1.
REQ-031 SHALL, when frame_req arrives with pending=1, increment drop_cnt, saturating at 255.
REQ-032 SHALL give clr_req priority when frame_req and clr_req coincide: the abort or ignore rule applies first, and frame_req is still queued per REQ-030/031.
REQ-033 SHALL give tx_done and clr_req coinciding in WAIT_TX one transition, with wd_err=0.
REQ-034 SHALL ignore tx_done outside WAIT_TX.
REQ-035 SHALL make all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-036 SHALL, while RESET=1 at a clock edge, force state=IDLE, cnt=0, pending=0, dir_RX=0, dir_TX=0, addr_ena=0, busy=0, wd_err=0 and drop_cnt=0, overriding all other inputs.
REQ-037 SHALL abandon any sequence on RESET mid-operation, with no release phasing; the first request is accepted on the cycle after RESET deasserts.

Verification
REQ-038 SHALL be verified by the normal cycle: frame_req at edge 0 -> dir_RX rises at edge 1001, dir_TX and addr_ena rise at edge 1501, addr_ena falls at 2001; tx_done at 2100 -> dir_TX falls at 2101, dir_RX falls at 2601, IDLE at 2602.
REQ-039 SHALL be verified by an abort: clr_req at edge 1200 (TX_SW) -> dir_TX stays 0, dir_RX falls at 1701, IDLE at 1702, wd_err=0.
REQ-040 SHALL be verified by the watchdog: no tx_done after edge 1501 -> WAIT_TX entered at 2001, wd_err pulses and the state changes to REL_TX at edge 6001, dir_RX falls at 6501.
REQ-041 SHALL be verified by queueing: three frame_req pulses during RX_SW -> pending=1, drop_cnt=2; after the first sequence ends, a second sequence starts one cycle after IDLE is entered.
REQ-042 SHALL be verified by RESET asserted at edge 1700 (ADDR) -> at edge 1701 all outputs are 0 and state=0; frame_req at 1702 -> dir_RX rises at 2703.
REQ-043 SHALL be verified by coincidence: clr_req and tx_done together in WAIT_TX -> a single REL_TX entry with wd_err=0; 300 dropped requests -> drop_cnt holds at 255.

Source files
------------

// File: rtl/dir_seq_arbiter_if.sv
// Handshake and status bundle between the MFK request side and the direction arbiter.
interface dir_seq_arbiter_if;
    logic       frame_req;
    logic       clr_req;
    logic       tx_done;
    logic       dir_RX;
    logic       dir_TX;
    logic       addr_ena;
    logic       busy;
    logic [2:0] state;
    logic [7:0] drop_cnt;
    logic       wd_err;

    modport master (
        output frame_req, clr_req, tx_done,
        input  dir_RX, dir_TX, addr_ena, busy, state, drop_cnt, wd_err
    );

    modport slave (
        input  frame_req, clr_req, tx_done,
        output dir_RX, dir_TX, addr_ena, busy, state, drop_cnt, wd_err
    );
endinterface

// File: rtl/dir_seq_arbiter.sv
// Line direction sequencer: phases receiver/transmitter enables around one response frame,
// with a one-deep request queue, abort on clr_req and a watchdog on the transmit wait.
module dir_seq_arbiter #(
    parameter int T_RX   = 1000,
    parameter int T_TX   = 500,
    parameter int T_ADDR = 500,
    parameter int T_REL  = 500,
    parameter int T_WD   = 4000
) (
    input  logic                  clk,
    input  logic                  RESET,
    dir_seq_arbiter_if.slave      bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_SW   = 3'd1,
        TX_SW   = 3'd2,
        ADDR    = 3'd3,
        WAIT_TX = 3'd4,
        REL_TX  = 3'd5,
        REL_RX  = 3'd6
    } state_t;

    localparam logic [11:0] RX_LAST   = 12'(T_RX - 1);
    localparam logic [11:0] TX_LAST   = 12'(T_TX - 1);
    localparam logic [11:0] ADDR_LAST = 12'(T_ADDR - 1);
    localparam logic [11:0] REL_LAST  = 12'(T_REL - 1);
    localparam logic [11:0] WD_LAST   = 12'(T_WD - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [11:0] cnt_r;
    logic        pending_r;
    logic        pending_nxt_s;
    logic [7:0]  drop_r;
    logic [7:0]  drop_nxt_s;
    logic        dir_rx_r;
    logic        dir_rx_nxt_s;
    logic        dir_tx_r;
    logic        dir_tx_nxt_s;
    logic        addr_ena_r;
    logic        addr_ena_nxt_s;
    logic        busy_r;
    logic        wd_err_r;
    logic        wd_fire_s;

    // State, phase counter, queue and registered outputs
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_r    <= IDLE;
            cnt_r      <= 12'd0;
            pending_r  <= 1'b0;
            drop_r     <= 8'd0;
            dir_rx_r   <= 1'b0;
            dir_tx_r   <= 1'b0;
            addr_ena_r <= 1'b0;
            busy_r     <= 1'b0;
            wd_err_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= (state_nxt_s != state_r) ? 12'd0 : cnt_r + 12'd1;
            pending_r  <= pending_nxt_s;
            drop_r     <= drop_nxt_s;
            dir_rx_r   <= dir_rx_nxt_s;
            dir_tx_r   <= dir_tx_nxt_s;
            addr_ena_r <= addr_ena_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
            wd_err_r   <= wd_fire_s;
        end
    end

    // Next-state selection; clr_req outranks the phase timers in the switching states
    always_comb begin
        state_nxt_s = state_r;
        wd_fire_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.frame_req || pending_r) state_nxt_s = RX_SW;
                else                            state_nxt_s = IDLE;
            end
            RX_SW: begin
                if (bus.clr_req)           state_nxt_s = REL_TX;
                else if (cnt_r == RX_LAST) state_nxt_s = TX_SW;
                else                       state_nxt_s = RX_SW;
            end
            TX_SW: begin
                if (bus.clr_req)           state_nxt_s = REL_TX;
                else if (cnt_r == TX_LAST) state_nxt_s = ADDR;
                else                       state_nxt_s = TX_SW;
            end
            ADDR: begin
                if (bus.clr_req)             state_nxt_s = REL_TX;
                else if (cnt_r == ADDR_LAST) state_nxt_s = WAIT_TX;
                else                         state_nxt_s = ADDR;
            end
            WAIT_TX: begin
                if (bus.tx_done || bus.clr_req) begin
                    state_nxt_s = REL_TX;
                end else if (cnt_r == WD_LAST) begin
                    state_nxt_s = REL_TX;
                    wd_fire_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT_TX;
                end
            end
            REL_TX: begin
                if (cnt_r == REL_LAST) state_nxt_s = REL_RX;
                else                   state_nxt_s = REL_TX;
            end
            REL_RX:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output and queue updates keyed on the state being entered
    always_comb begin
        dir_rx_nxt_s   = dir_rx_r;
        dir_tx_nxt_s   = dir_tx_r;
        addr_ena_nxt_s = addr_ena_r;
        pending_nxt_s  = pending_r;
        drop_nxt_s     = drop_r;

        if (state_nxt_s != state_r) begin
            case (state_nxt_s)
                TX_SW: dir_rx_nxt_s = 1'b1;
                ADDR: begin
                    dir_tx_nxt_s   = 1'b1;
                    addr_ena_nxt_s = 1'b1;
                end
                WAIT_TX: addr_ena_nxt_s = 1'b0;
                REL_TX: begin
                    dir_tx_nxt_s   = 1'b0;
                    addr_ena_nxt_s = 1'b0;
                end
                REL_RX: dir_rx_nxt_s = 1'b0;
                IDLE: begin
                    dir_rx_nxt_s   = 1'b0;
                    dir_tx_nxt_s   = 1'b0;
                    addr_ena_nxt_s = 1'b0;
                end
                default: dir_rx_nxt_s = dir_rx_r;
            endcase
        end else begin
            dir_rx_nxt_s = dir_rx_r;
        end

        // A request seen while one is already queued is counted as dropped
        if (state_r == IDLE) begin
            pending_nxt_s = 1'b0;
            if (bus.frame_req && pending_r) drop_nxt_s = sat_inc(drop_r);
            else                            drop_nxt_s = drop_r;
        end else if (bus.frame_req) begin
            if (pending_r) drop_nxt_s    = sat_inc(drop_r);
            else           pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    assign bus.state    = state_r;
    assign bus.dir_RX   = dir_rx_r;
    assign bus.dir_TX   = dir_tx_r;
    assign bus.addr_ena = addr_ena_r;
    assign bus.busy     = busy_r;
    assign bus.wd_err   = wd_err_r;
    assign bus.drop_cnt = drop_r;

endmodule
